// File: rtl/time_digits_pkg.sv
// time_digits_pkg: shared constants for the time-of-day display source.
//   - FSM state encoding (RUN / SET_HR / SET_MIN) and its typed enum
//   - BCD digit width, blank segment pattern, digit->segment table
//   - bcd_inc: wrap-around increment of a two-digit BCD field
package time_digits_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;

  typedef enum logic [1:0] {
    StRun    = RUN,
    StSetHr  = SET_HR,
    StSetMin = SET_MIN
  } state_e;

  // Active-low {g,f,e,d,c,b,a}; all segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Common-anode patterns, entry i is digit i.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Increment a {tens,units} BCD value, returning 00 after reaching last.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) begin
      return 8'h00;
    end
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low seven-segment pattern.
//   bcd  in  DIGIT_W  digit value; values above 9 produce SEG_BLANK
//   seg  out 7        {g,f,e,d,c,b,a}, 0 = lit
module seg7_decode
  import time_digits_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule

// File: rtl/time_digits.sv
// time_digits: 24-hour hh:mm:ss BCD clock with button-driven set mode, producing the
// registered segment pattern for the digit index presented by the display scanner.
//   CLK   in  1  scan clock, all state on posedge
//   RSTN  in  1  asynchronous active-low reset
//   SEL   in  3  digit index 0..5 (6/7 blank)
//   MODE  in  1  mode button, asynchronous, active-high
//   INC   in  1  increment button, asynchronous, active-high
//   SEG   out 7  active-low segments {g,f,e,d,c,b,a}, registered
//   DP    out 1  active-low decimal point, registered
//   HOUR/MIN/SEC out 8 each  current time in BCD
module time_digits
  import time_digits_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [2:0] SEL,
  input  logic       MODE,
  input  logic       INC,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_DIV / 2);

  // Button synchronizers and rising-edge detectors.
  logic [1:0] mode_sync_q, inc_sync_q;
  logic       mode_prev_q, inc_prev_q;
  logic       mode_rise, inc_rise;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_sync_q <= 2'b00;
      inc_sync_q  <= 2'b00;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      mode_sync_q <= {mode_sync_q[0], MODE};
      inc_sync_q  <= {inc_sync_q[0], INC};
      mode_prev_q <= mode_sync_q[1];
      inc_prev_q  <= inc_sync_q[1];
    end
  end

  assign mode_rise = mode_sync_q[1] & ~mode_prev_q;
  // A coincident MODE press swallows the INC press.
  assign inc_rise  = inc_sync_q[1] & ~inc_prev_q & ~mode_rise;

  // Mode FSM, prescaler and time registers.
  state_e           state_q;
  logic [PRE_W-1:0] pre_q;
  logic [7:0]       hour_q, min_q, sec_q;
  logic             tick;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StRun;
      pre_q   <= '0;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
    end else begin
      // Prescaler free-runs in every state so set-mode blink keeps its cadence.
      pre_q <= tick ? '0 : pre_q + 1'b1;
      unique case (state_q)
        StRun: begin
          if (tick) begin
            sec_q <= bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
              min_q <= bcd_inc(min_q, 8'h59);
              if (min_q == 8'h59) begin
                hour_q <= bcd_inc(hour_q, 8'h23);
              end
            end
          end
          if (mode_rise) begin
            state_q <= StSetHr;
          end
        end
        StSetHr: begin
          if (mode_rise) begin
            state_q <= StSetMin;
          end else if (inc_rise) begin
            hour_q <= bcd_inc(hour_q, 8'h23);
          end
        end
        StSetMin: begin
          if (mode_rise) begin
            // Leaving set mode restarts the second cleanly.
            state_q <= StRun;
            sec_q   <= 8'h00;
            pre_q   <= '0;
          end else if (inc_rise) begin
            min_q <= bcd_inc(min_q, 8'h59);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Digit selection and blink.
  logic [DIGIT_W-1:0] digit;
  logic               blank;
  logic               blink_phase;
  logic [6:0]         digit_seg;

  assign blink_phase = (pre_q >= PRE_HALF);

  always_comb begin
    digit = '0;
    blank = 1'b0;
    unique case (SEL)
      3'd0:    digit = hour_q[7:4];
      3'd1:    digit = hour_q[3:0];
      3'd2:    digit = min_q[7:4];
      3'd3:    digit = min_q[3:0];
      3'd4:    digit = sec_q[7:4];
      3'd5:    digit = sec_q[3:0];
      default: blank = 1'b1;
    endcase
    if (blink_phase &&
        ((state_q == StSetHr  && (SEL == 3'd0 || SEL == 3'd1)) ||
         (state_q == StSetMin && (SEL == 3'd2 || SEL == 3'd3)))) begin
      blank = 1'b1;
    end
  end

  seg7_decode u_decode (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Registered so segments line up with the scanner's registered enables.
  logic [6:0] seg_q;
  logic       dp_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= blank ? SEG_BLANK : digit_seg;
      dp_q  <= ~(SEL == 3'd1 || SEL == 3'd3);
    end
  end

  assign SEG  = seg_q;
  assign DP   = dp_q;
  assign HOUR = hour_q;
  assign MIN  = min_q;
  assign SEC  = sec_q;

endmodule

// File: tb/tb_time_digits.sv
module tb_time_digits;

  localparam int unsigned TD = 4;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [2:0] SEL = 3'd0;
  logic       MODE = 1'b0;
  logic       INC = 1'b0;
  logic [6:0] SEG;
  logic       DP;
  logic [7:0] HOUR, MIN, SEC;

  int checks = 0;
  int failures = 0;

  time_digits #(.TICK_DIV(TD)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .SEL  (SEL),
    .MODE (MODE),
    .INC  (INC),
    .SEG  (SEG),
    .DP   (DP),
    .HOUR (HOUR),
    .MIN  (MIN),
    .SEC  (SEC)
  );

  always #5 CLK = ~CLK;

  // Reference model: time as plain integers, mode 0=run 1=set hour 2=set minute.
  int         m_h, m_m, m_s, m_pre, m_st;
  logic [6:0] m_seg;
  logic       m_dp;
  // Button levels sampled 1, 2 and 3 edges ago.
  bit         md1, md2, md3, id1, id2, id3;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int sel);
    int d;
    if (sel > 5) return 7'h7F;
    if (m_pre >= int'(TD / 2) &&
        ((m_st == 1 && sel < 2) || (m_st == 2 && (sel == 2 || sel == 3)))) return 7'h7F;
    case (sel)
      0: d = m_h / 10;
      1: d = m_h % 10;
      2: d = m_m / 10;
      3: d = m_m % 10;
      4: d = m_s / 10;
      default: d = m_s % 10;
    endcase
    return pat(d);
  endfunction

  function automatic logic [2:0] rsel();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_pre = 0; m_st = 0;
    m_seg = 7'h7F; m_dp = 1'b1;
    md1 = 0; md2 = 0; md3 = 0; id1 = 0; id2 = 0; id3 = 0;
  endtask

  task automatic model_edge();
    bit mr, ir, tk;
    int t;
    m_seg = exp_seg(int'(SEL));
    m_dp  = (SEL == 3'd1 || SEL == 3'd3) ? 1'b0 : 1'b1;
    mr = md2 && !md3;
    ir = id2 && !id3 && !mr;
    tk = (m_pre == int'(TD) - 1);
    m_pre = tk ? 0 : m_pre + 1;
    case (m_st)
      0: begin
        if (tk) begin
          t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
        end
        if (mr) m_st = 1;
      end
      1: begin
        if (mr) m_st = 2;
        else if (ir) m_h = (m_h + 1) % 24;
      end
      default: begin
        if (mr) begin
          m_st = 0; m_s = 0; m_pre = 0;
        end else if (ir) m_m = (m_m + 1) % 60;
      end
    endcase
    md3 = md2; md2 = md1; md1 = MODE;
    id3 = id2; id2 = id1; id1 = INC;
  endtask

  // Drive inputs now, advance one edge, update the model, settle.
  task automatic step(input logic mv, input logic iv, input logic [2:0] sv);
    MODE = mv; INC = iv; SEL = sv;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // One press: high for one sample; its action lands on the third edge.
  task automatic press(input logic mv, input logic iv);
    step(mv, iv, rsel());
    step(1'b0, 1'b0, rsel());
    step(1'b0, 1'b0, rsel());
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #1;
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; MODE = 1'b0; INC = 1'b0; SEL = 3'd5;
    #12;
    model_reset();
    checks++;
    if (SEG !== 7'h7F) begin
      failures++; $display("FAIL reset_seg: got %h expected 7f", SEG);
    end
    checks++;
    if (DP !== 1'b1) begin
      failures++; $display("FAIL reset_dp: got %b expected 1", DP);
    end
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000000) begin
      failures++; $display("FAIL reset_time: got %h expected 000000", {HOUR, MIN, SEC});
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_count();
    do_reset();
    // Random SEL, stray INC presses in run mode must be ignored.
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'($urandom_range(0, 1)), rsel());
      checks++;
      if (SEG !== m_seg || DP !== m_dp) begin
        failures++; $display("FAIL count_seg: got %h/%b expected %h/%b", SEG, DP, m_seg, m_dp);
      end
      checks++;
      if ({HOUR, MIN, SEC} !== {bcd(m_h), bcd(m_m), bcd(m_s)}) begin
        failures++; $display("FAIL count_time: got %h expected %h",
                             {HOUR, MIN, SEC}, {bcd(m_h), bcd(m_m), bcd(m_s)});
      end
    end
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000004) begin
      failures++; $display("FAIL count_four_ticks: got %h expected 000004", {HOUR, MIN, SEC});
    end
    step(1'b0, 1'b0, 3'd5);
    checks++;
    if (SEG !== 7'h19) begin
      failures++; $display("FAIL count_sel5: got %h expected 19", SEG);
    end
  endtask

  task automatic test_rollover();
    do_reset();
    press(1'b1, 1'b0);
    for (int p = 0; p < 23; p++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int p = 0; p < 59; p++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h235900) begin
      failures++; $display("FAIL roll_set: got %h expected 235900", {HOUR, MIN, SEC});
    end
    for (int c = 0; c < 58 * 4; c++) begin
      step(1'b0, 1'b0, rsel());
      checks++;
      if ({HOUR, MIN, SEC} !== {bcd(m_h), bcd(m_m), bcd(m_s)} || SEG !== m_seg) begin
        failures++; $display("FAIL roll_run: got %h/%h expected %h/%h", {HOUR, MIN, SEC}, SEG,
                             {bcd(m_h), bcd(m_m), bcd(m_s)}, m_seg);
      end
    end
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h235958) begin
      failures++; $display("FAIL roll_58: got %h expected 235958", {HOUR, MIN, SEC});
    end
    for (int c = 0; c < 7; c++) step(1'b0, 1'b0, rsel());
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h235959) begin
      failures++; $display("FAIL roll_59: got %h expected 235959", {HOUR, MIN, SEC});
    end
    step(1'b0, 1'b0, rsel());
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000000) begin
      failures++; $display("FAIL roll_wrap: got %h expected 000000", {HOUR, MIN, SEC});
    end
  endtask

  task automatic test_set_hour();
    int nblank;
    do_reset();
    press(1'b1, 1'b0);
    // Random hold lengths: a held INC must count once.
    for (int p = 0; p < 25; p++) begin
      int hi, lo;
      hi = $urandom_range(1, 4);
      lo = $urandom_range(1, 3);
      for (int c = 0; c < hi + lo; c++) begin
        step(1'b0, c < hi, rsel());
        checks++;
        if (SEG !== m_seg || DP !== m_dp) begin
          failures++; $display("FAIL sethr_seg: got %h/%b expected %h/%b", SEG, DP, m_seg, m_dp);
        end
        checks++;
        if ({HOUR, MIN, SEC} !== {bcd(m_h), bcd(m_m), bcd(m_s)}) begin
          failures++; $display("FAIL sethr_time: got %h expected %h",
                               {HOUR, MIN, SEC}, {bcd(m_h), bcd(m_m), bcd(m_s)});
        end
      end
    end
    step(1'b0, 1'b0, rsel());
    step(1'b0, 1'b0, rsel());
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h010000) begin
      failures++; $display("FAIL sethr_final: got %h expected 010000", {HOUR, MIN, SEC});
    end
    nblank = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 3'd0);
      if (SEG === 7'h7F) nblank++;
    end
    checks++;
    if (nblank != 2) begin
      failures++; $display("FAIL sethr_blink: got %0d blank cycles expected 2", nblank);
    end
  endtask

  task automatic test_set_min();
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    for (int p = 0; p < 3; p++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000300) begin
      failures++; $display("FAIL setmin_exit: got %h expected 000300", {HOUR, MIN, SEC});
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, rsel());
      checks++;
      if (SEC !== 8'h00) begin
        failures++; $display("FAIL setmin_no_tick: got %h expected 00", SEC);
      end
    end
    step(1'b0, 1'b0, rsel());
    checks++;
    if (SEC !== 8'h01) begin
      failures++; $display("FAIL setmin_first_tick: got %h expected 01", SEC);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    press(1'b1, 1'b1);
    checks++;
    if (HOUR !== 8'h00) begin
      failures++; $display("FAIL coin_run_hour: got %h expected 00", HOUR);
    end
    press(1'b0, 1'b1);
    checks++;
    if (HOUR !== 8'h01) begin
      failures++; $display("FAIL coin_in_sethr: got %h expected 01", HOUR);
    end
    // In SET_HR a coincident press must advance mode and drop the increment.
    press(1'b1, 1'b1);
    press(1'b0, 1'b1);
    checks++;
    if ({HOUR, MIN} !== 16'h0101) begin
      failures++; $display("FAIL coin_sethr: got %h expected 0101", {HOUR, MIN});
    end
    // Tick landing on the edge that enters SET_HR is kept.
    do_reset();
    step(1'b0, 1'b0, rsel());
    press(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, rsel());
    checks++;
    if (SEC !== 8'h01 || SEC !== bcd(m_s)) begin
      failures++; $display("FAIL tick_into_set: got %h expected 01", SEC);
    end
  endtask

  task automatic test_blank_reset();
    step(1'b0, 1'b0, 3'd6);
    checks++;
    if (SEG !== 7'h7F || DP !== 1'b1) begin
      failures++; $display("FAIL sel6_blank: got %h/%b expected 7f/1", SEG, DP);
    end
    step(1'b0, 1'b0, 3'd7);
    checks++;
    if (SEG !== 7'h7F || DP !== 1'b1) begin
      failures++; $display("FAIL sel7_blank: got %h/%b expected 7f/1", SEG, DP);
    end
    do_reset();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if ({HOUR, MIN} !== 16'h0101) begin
      failures++; $display("FAIL pre_reset_set: got %h expected 0101", {HOUR, MIN});
    end
    SEL = 3'd1;
    #2;
    RSTN = 1'b0;
    #1;
    checks++;
    if (SEG !== 7'h7F || DP !== 1'b1 || {HOUR, MIN, SEC} !== 24'h000000) begin
      failures++; $display("FAIL async_reset: got %h/%b/%h expected 7f/1/000000",
                           SEG, DP, {HOUR, MIN, SEC});
    end
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 3'd5);
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000001 || SEG !== m_seg) begin
      failures++; $display("FAIL reset_to_run: got %h/%h expected 000001/%h",
                           {HOUR, MIN, SEC}, SEG, m_seg);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_set_hour();
    test_set_min();
    test_coincide();
    test_blank_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_digits.md
# time_digits

Time-of-day source for the six-digit multiplexed LED display. Keeps a 24-hour hh:mm:ss BCD time with button-driven set mode. Emits, for the digit index presented by the display scanner on SEL, the active-low segment pattern. Sits directly upstream of the scanner: it consumes the scanner's SEL and produces the segment lines that the scanner's digit enables strobe.

## Interface
Parameters:
- TICK_DIV, 1000: CLK cycles per one-second tick (CLK is the scan clock). Legal range is ≥2.

Ports:
- CLK  in  1  sole clock; all state updates on posedge.
- RSTN  in  1  reset, asynchronous, active-low.
- SEL  in  3  digit index from the scanner, counting 0..5.
- MODE  in  1  mode button, active-high, asynchronous to CLK.
- INC  in  1  increment button, active-high, asynchronous to CLK.
- SEG  out  7  {g,f,e,d,c,b,a}, active-low (0 = lit).
- DP  out  1  decimal point, active-low.
- HOUR  out  8  BCD {tens,units}, 00..23.
- MIN  out  8  BCD, 00..59.
- SEC  out  8  BCD, 00..59.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` = prescaler at TICK_DIV-1, one cycle wide.
- FSM states are RUN, SET_HR, SET_MIN.
  - A MODE press moves RUN→SET_HR→SET_MIN→RUN.
  - On the SET_MIN→RUN transition: SEC←00 and prescaler←0.
- RUN: each tick increments SEC.
  - 59→00 carries into MIN; MIN 59→00 carries into HOUR; HOUR 23→00.
  - 23:59:59 becomes 00:00:00 on a single tick.
- SET_HR: each INC press increments HOUR (23→00). No carry. Ticks are ignored (time frozen), but the prescaler keeps running for blink.
- SET_MIN: same as SET_HR, applied to MIN (59→00). HOUR is untouched.
- Buttons: each input passes through a 2-flop synchronizer, then a rising-edge detect. One press = one action. Held levels do not repeat.
- If MODE and INC pulses coincide, MODE wins and INC is dropped.
- Digit map:
  - SEL 0 = HOUR tens, 1 = HOUR units, 2 = MIN tens, 3 = MIN units, 4 = SEC tens, 5 = SEC units.
  - SEL 6/7 → SEG=7'h7F, DP=1 (blank).
- Leading zeros are displayed.
- Blink: in SET_HR (or SET_MIN), the two digits of the field being set show SEG=7'h7F while prescaler ≥ TICK_DIV/2.
- DP = 0 on SEL 1 and SEL 3, otherwise 1. DP does not blink.
- Decode patterns for digits 0..9 are the standard common-anode patterns (0 = 7'h40, 1 = 7'h79, 8 = 7'h00).

## Timing
- Reset (RSTN low, asynchronous): time 00:00:00, state RUN, prescaler 0, synchronizer and edge flops 0, SEG = 7'h7F, DP = 1.
  - Reset asserted mid-set-mode returns to RUN at 00:00:00.
- SEG/DP are registered. SEG/DP after posedge k reflect SEL sampled at posedge k. This aligns with the scanner's registered enables for the same index.
- Time update: SEC/MIN/HOUR change at the posedge where tick = 1. Outputs are visible the same cycle after that edge.
- Button latency: if a button is sampled high first at posedge k, its action takes effect at posedge k+2.
- An INC that arrives in RUN is ignored.
- A tick coinciding with the MODE transition into SET_HR is still applied. The frozen time includes that increment.

## Structure
- Package `time_digits_pkg` holds:
  - FSM state encoding (2-bit localparams RUN/SET_HR/SET_MIN).
  - SEG_BLANK = 7'h7F.
  - The 10-entry digit→segment constant set.
  - BCD digit width (4).
- Sub-module `seg7_decode`: combinational 4-bit BCD → 7-bit active-low pattern. Inputs >9 give SEG_BLANK.
- Button synchronizer and edge-detect are instantiated twice, inline. No separate module.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset then 4 ticks → SEC = 04, MIN = 00, HOUR = 00. SEL = 5 → SEG = 7'h19 (digit 4).
- Force time 23:59:58 via set mode plus ticks, then apply 2 ticks → 00:00:00 after the second tick, carried in a single edge.
- MODE once, INC ×25 → HOUR = 01 (wraps past 23). Ticks during this change nothing. Hour digits blank while prescaler ≥ 2.
- MODE, MODE, INC ×3, MODE → MIN = +3, SEC = 00, prescaler = 0, state RUN. The next tick arrives 4 cycles later.
- MODE and INC rising in the same cycle while in RUN → state SET_HR, HOUR unchanged.
- SEL = 6 → SEG = 7'h7F, DP = 1. Assert RSTN low during SET_MIN → immediate SEG = 7'h7F, time 00:00:00, state RUN.
